// File: rtl/fft_pkg.sv
// Shared types and sizes for the FFT sample buffer and the FFT core datapath.
// buff_t is the packed whole-buffer bus used for both bulk load and readout.
package fft_pkg;

    localparam int NUM_WORDS = 512;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 10;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef logic [DATA_W-1:0]                 sample_t;
    typedef logic [ADDR_W-1:0]                 addr_t;
    typedef logic [NUM_WORDS-1:0][DATA_W-1:0]  buff_t;

endpackage

// File: rtl/mem_buff.sv
// 512 x 16 register-file buffer: bulk load on fft_start, single-word SRAM-style
// write/read by address, and the whole contents exposed on all_data.
module mem_buff
    import fft_pkg::*;
(
    input  logic    clk,
    input  logic    n_rst,
    input  logic    fft_start,
    input  logic    sram_read_ena,
    input  logic    sram_write_ena,
    input  sample_t write_data,
    input  addr_t   address,
    input  buff_t   main_data,
    output sample_t sample,
    output buff_t   all_data
);

    buff_t           mem;
    logic            in_range;
    logic [IDX_W-1:0] idx;

    // The address bus is one bit wider than the array; the upper half maps to nothing.
    assign in_range = (address < ADDR_W'(NUM_WORDS));
    assign idx      = address[IDX_W-1:0];

    // Bulk load wins over a same-edge single-word write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem <= '0;
        end else if (fft_start) begin
            mem <= main_data;
        end else if (sram_write_ena && in_range) begin
            mem[idx] <= write_data;
        end
    end

    // Reads sample the pre-edge contents, so a same-edge write or load is not seen.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sample <= '0;
        end else if (sram_read_ena) begin
            sample <= in_range ? mem[idx] : '0;
        end
    end

    assign all_data = mem;

endmodule

// File: tb/tb_mem_buff.sv
// Directed bench for mem_buff: reset, bulk load, single writes/reads,
// collisions, out-of-range addressing and mid-operation reset.
module tb_mem_buff;
    import fft_pkg::*;

    logic    clk;
    logic    n_rst;
    logic    fft_start;
    logic    sram_read_ena;
    logic    sram_write_ena;
    sample_t write_data;
    addr_t   address;
    buff_t   main_data;
    sample_t sample;
    buff_t   all_data;

    buff_t   exp_mem;
    logic [DATA_W-1:0] exp_q[$];
    int      checks_total;
    int      checks_passed;

    mem_buff dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .fft_start      (fft_start),
        .sram_read_ena  (sram_read_ena),
        .sram_write_ena (sram_write_ena),
        .write_data     (write_data),
        .address        (address),
        .main_data      (main_data),
        .sample         (sample),
        .all_data       (all_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff(input buff_t a, input buff_t b);
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (a[i] !== b[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int d;
        #2 n_rst = 1'b0;
        #1;
        checks_total++;
        if (sample !== 16'h0000)
            $display("FAIL reset_sample: got %h expected 0000", sample);
        else checks_passed++;
        d = first_diff(all_data, '0);
        checks_total++;
        if (d >= 0)
            $display("FAIL reset_all_data: entry %0d got %h expected 0000", d, all_data[d]);
        else checks_passed++;
        @(negedge clk);
        n_rst = 1'b1;
        exp_mem = '0;
    endtask

    task automatic test_bulk_load();
        int d;
        tick();
        for (int i = 0; i < NUM_WORDS; i++) main_data[i] = 16'(i);
        fft_start = 1'b1;
        tick();
        fft_start = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) exp_mem[i] = 16'(i);
        d = first_diff(all_data, exp_mem);
        checks_total++;
        if (d >= 0)
            $display("FAIL bulk_load: entry %0d got %h expected %h", d, all_data[d], exp_mem[d]);
        else checks_passed++;
        checks_total++;
        if (all_data[511] !== 16'd511)
            $display("FAIL bulk_load_511: got %0d expected 511", all_data[511]);
        else checks_passed++;
    endtask

    task automatic test_single_writes();
        int d;
        for (int i = 10; i <= 299; i++) begin
            sram_write_ena = 1'b1;
            address        = addr_t'(i);
            write_data     = 16'(i + 512);
            exp_mem[i]     = 16'(i + 512);
            tick();
        end
        sram_write_ena = 1'b0;
        checks_total++;
        if (all_data[10] !== 16'd522)
            $display("FAIL write_10: got %0d expected 522", all_data[10]);
        else checks_passed++;
        checks_total++;
        if (all_data[299] !== 16'd811)
            $display("FAIL write_299: got %0d expected 811", all_data[299]);
        else checks_passed++;
        checks_total++;
        if (all_data[9] !== 16'd9)
            $display("FAIL write_neighbour_9: got %0d expected 9", all_data[9]);
        else checks_passed++;
        checks_total++;
        if (all_data[300] !== 16'd300)
            $display("FAIL write_neighbour_300: got %0d expected 300", all_data[300]);
        else checks_passed++;
        d = first_diff(all_data, exp_mem);
        checks_total++;
        if (d >= 0)
            $display("FAIL write_all: entry %0d got %h expected %h", d, all_data[d], exp_mem[d]);
        else checks_passed++;
    endtask

    task automatic test_sequential_reads();
        logic [DATA_W-1:0] exp_s;
        int errs;
        errs = 0;
        for (int a = 0; a < NUM_WORDS; a++) begin
            sram_read_ena = 1'b1;
            address       = addr_t'(a);
            exp_q.push_back(exp_mem[a]);
            tick();
            exp_s = exp_q.pop_front();
            if (sample !== exp_s) begin
                errs++;
                if (errs <= 8)
                    $display("FAIL read_addr_%0d: got %h expected %h", a, sample, exp_s);
            end
            if (a == 5 || a == 10 || a == 299 || a == 511) begin
                checks_total++;
                if ((a == 5   && sample !== 16'd5)   || (a == 10  && sample !== 16'd522) ||
                    (a == 299 && sample !== 16'd811) || (a == 511 && sample !== 16'd511))
                    $display("FAIL read_spot_%0d: got %0d", a, sample);
                else checks_passed++;
            end
        end
        checks_total++;
        if (errs != 0)
            $display("FAIL read_sweep: %0d wrong samples, expected 0", errs);
        else checks_passed++;
        sram_read_ena = 1'b0;
        address       = addr_t'(5);
        tick();
        tick();
        checks_total++;
        if (sample !== 16'd511)
            $display("FAIL read_hold: got %0d expected 511", sample);
        else checks_passed++;
    endtask

    task automatic test_collisions();
        // fft_start and a write on the same edge: load wins
        fft_start      = 1'b1;
        sram_write_ena = 1'b1;
        address        = addr_t'(20);
        write_data     = 16'hBEEF;
        tick();
        fft_start      = 1'b0;
        sram_write_ena = 1'b0;
        exp_mem        = main_data;
        checks_total++;
        if (all_data[20] !== 16'd20)
            $display("FAIL load_vs_write_20: got %h expected 0014", all_data[20]);
        else checks_passed++;
        checks_total++;
        if (all_data[10] !== 16'd10)
            $display("FAIL load_vs_write_10: got %h expected 000a", all_data[10]);
        else checks_passed++;

        // read + write same address on one edge
        sram_read_ena  = 1'b1;
        sram_write_ena = 1'b1;
        address        = addr_t'(30);
        write_data     = 16'hCAFE;
        tick();
        sram_write_ena = 1'b0;
        exp_mem[30]    = 16'hCAFE;
        checks_total++;
        if (sample !== 16'd30)
            $display("FAIL rw_same_old: got %h expected 001e", sample);
        else checks_passed++;
        checks_total++;
        if (all_data[30] !== 16'hCAFE)
            $display("FAIL rw_same_stored: got %h expected cafe", all_data[30]);
        else checks_passed++;
        tick();
        checks_total++;
        if (sample !== 16'hCAFE)
            $display("FAIL rw_same_new: got %h expected cafe", sample);
        else checks_passed++;

        // read during bulk load returns pre-load value
        main_data[40] = 16'hAAAA;
        fft_start     = 1'b1;
        address       = addr_t'(40);
        tick();
        fft_start     = 1'b0;
        sram_read_ena = 1'b0;
        checks_total++;
        if (sample !== 16'd40)
            $display("FAIL read_during_load: got %h expected 0028", sample);
        else checks_passed++;
        checks_total++;
        if (all_data[40] !== 16'hAAAA)
            $display("FAIL load_entry_40: got %h expected aaaa", all_data[40]);
        else checks_passed++;
        exp_mem = main_data;
    endtask

    task automatic test_reset_mid();
        int d;
        sram_read_ena = 1'b1;
        address       = addr_t'(40);
        tick();
        sram_read_ena = 1'b0;
        checks_total++;
        if (sample !== 16'hAAAA)
            $display("FAIL pre_reset_sample: got %h expected aaaa", sample);
        else checks_passed++;
        #2 n_rst = 1'b0;
        #1;
        checks_total++;
        if (sample !== 16'h0000)
            $display("FAIL mid_reset_sample: got %h expected 0000", sample);
        else checks_passed++;
        d = first_diff(all_data, '0);
        checks_total++;
        if (d >= 0)
            $display("FAIL mid_reset_all_data: entry %0d got %h expected 0000", d, all_data[d]);
        else checks_passed++;
        // enables held during reset must have no effect
        fft_start      = 1'b1;
        sram_write_ena = 1'b1;
        sram_read_ena  = 1'b1;
        write_data     = 16'h7777;
        address        = addr_t'(3);
        tick();
        d = first_diff(all_data, '0);
        checks_total++;
        if (d >= 0 || sample !== 16'h0000)
            $display("FAIL reset_held_enables: sample %h, first nonzero entry %0d", sample, d);
        else checks_passed++;
        fft_start      = 1'b0;
        sram_write_ena = 1'b0;
        sram_read_ena  = 1'b0;
        @(negedge clk);
        n_rst   = 1'b1;
        exp_mem = '0;
    endtask

    task automatic test_out_of_range();
        int d;
        tick();
        for (int i = 0; i < NUM_WORDS; i++) main_data[i] = 16'(i);
        fft_start = 1'b1;
        tick();
        fft_start = 1'b0;
        exp_mem   = main_data;

        sram_write_ena = 1'b1;
        address        = addr_t'(600);
        write_data     = 16'h1234;
        tick();
        address        = addr_t'(512);
        write_data     = 16'h5555;
        tick();
        sram_write_ena = 1'b0;
        d = first_diff(all_data, exp_mem);
        checks_total++;
        if (d >= 0)
            $display("FAIL oor_write: entry %0d got %h expected %h", d, all_data[d], exp_mem[d]);
        else checks_passed++;

        sram_read_ena = 1'b1;
        address       = addr_t'(5);
        tick();
        address       = addr_t'(600);
        tick();
        checks_total++;
        if (sample !== 16'h0000)
            $display("FAIL oor_read_600: got %h expected 0000", sample);
        else checks_passed++;
        address = addr_t'(7);
        tick();
        checks_total++;
        if (sample !== 16'd7)
            $display("FAIL read_7: got %h expected 0007", sample);
        else checks_passed++;
        address = addr_t'(512);
        tick();
        sram_read_ena = 1'b0;
        checks_total++;
        if (sample !== 16'h0000)
            $display("FAIL oor_read_512: got %h expected 0000", sample);
        else checks_passed++;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_rst          = 1'b1;
        fft_start      = 1'b0;
        sram_read_ena  = 1'b0;
        sram_write_ena = 1'b0;
        write_data     = '0;
        address        = '0;
        main_data      = '0;
        exp_mem        = '0;
        checks_total   = 0;
        checks_passed  = 0;

        test_reset();
        test_bulk_load();
        test_single_writes();
        test_sequential_reads();
        test_collisions();
        test_reset_mid();
        test_out_of_range();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mem_buff.md
Name: mem_buff

Overview:
- 512 x 16-bit register-file buffer between the sample SRAM interface and the FFT core.
- On fft_start, the whole buffer is bulk-loaded from the main_data bus.
- Individual words are then written or read through a single-port SRAM-style address/enable interface.
- The full buffer contents are always visible on all_data for the FFT datapath.

Parameters:
- NUM_WORDS, 512, number of 16-bit entries.
- DATA_W, 16, word width in bits.
- ADDR_W, 10, address width (one bit wider than needed for 512 entries).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- fft_start  input  1  bulk-load strobe.
- sram_read_ena  input  1  single-word read enable.
- sram_write_ena  input  1  single-word write enable.
- write_data  input  16  data for single-word write.
- address  input  10  word address for read/write.
- main_data  input  512x16 (packed [511:0][15:0])  bulk-load source; element i goes to entry i.
- sample  output  16  registered read data.
- all_data  output  512x16 (packed [511:0][15:0])  current buffer contents; element i = entry i.

Behaviour:
- One clock; reset is asynchronous and active-low (n_rst). While n_rst = 0, all 512 entries = 0 and sample = 0, independent of clk.
- Bulk load: fft_start = 1 at a rising edge -> every entry i <= main_data[i] on that edge.
  - fft_start is level-sensitive; holding it high reloads every cycle.
- Write: sram_write_ena = 1 and fft_start = 0 at an edge -> entry[address] <= write_data.
  - Only the addressed word changes; all others hold.
- Read: sram_read_ena = 1 at an edge -> sample <= entry[address] (value before any same-edge update).
  - Latency is 1 cycle.
  - sample holds its last value while sram_read_ena = 0.
- Priority: fft_start overrides sram_write_ena. Reads are independent and always return pre-edge contents.
  - Read + write to the same address on one edge: sample gets the old word; the new word is visible one cycle later.
  - Read during fft_start: sample gets the pre-load value.
- Out of range (address >= 512, i.e. address[9] = 1): writes are ignored; reads load sample with 0.
- all_data is driven continuously from storage, with no extra latency beyond the storage registers.
  - A write at edge N is visible on all_data just after edge N.
- Reset mid-operation clears storage and sample immediately. Pending enables have no effect until n_rst returns high.
- No internal state machine; purely enable-driven storage.

Decomposition:
- Shared package fft_pkg holds:
  - localparams NUM_WORDS = 512, DATA_W = 16, ADDR_W = 10.
  - typedef sample_t (logic [15:0]).
  - typedef buff_t (logic [511:0][15:0]), reused by the FFT core for the main_data/all_data buses.
- No sub-module: a single flat module with one storage always_ff block, a registered read path and a continuous all_data assignment.

Test Plan:
- Reset: assert n_rst = 0 mid-cycle -> sample = 0 and all_data = all zeros immediately, without waiting for a clk edge.
- Bulk load: main_data[i] = i for i = 0..511, pulse fft_start for one cycle -> all_data[i] = i for all i; all_data[511] = 511.
- Single writes after load: write i+512 to address i for i = 10..299, one write per cycle.
  - all_data[10] = 522, all_data[299] = 811.
  - all_data[9] = 9 and all_data[300] = 300 are unchanged.
- Sequential reads: read addresses 0..511, one per cycle.
  - sample one cycle later: addr 5 -> 5, addr 10 -> 522, addr 299 -> 811, addr 511 -> 511.
  - sample holds when sram_read_ena = 0.
- Collisions:
  - fft_start and a write to addr 20 (value 0xBEEF) on the same edge -> entry 20 = main_data[20].
  - Read + write to addr 30 on the same edge -> sample = old value; a next-cycle read returns the new value.
- Out of range: write 0x1234 to address 600 -> all_data unchanged; read address 600 -> sample = 0.
